// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared types and defaults for the multiplier scheduler
package mult_pkg;

   localparam int XLEN_DEFAULT = 16;

   typedef enum logic [1:0] {
      DP_READY   = 2'd0,
      DP_OPERATE = 2'd1,
      DP_DONE    = 2'd2
   } dp_state_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_OPERATE,
      S_DONE,
      S_RESP
   } sched_state_t;

endpackage

// File: rtl/mult_sched_if.sv
// rtl/mult_sched_if.sv - requester/response bus between clients and the scheduler
interface mult_sched_if
   import mult_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*XLEN-1:0] req_a;
   logic [NREQ*XLEN-1:0] req_b;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [2*XLEN-1:0]    resp_product;
   logic [IDW-1:0]       resp_id;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_product, resp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_product, resp_id
   );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// rtl/mult_sched_rr_arbiter.sv - round-robin grant starting the search at ptr
module rr_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      any = found;
      gnt = found ? (NREQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - schedules requesters onto an external multiply datapath; MULT_SCHED_ZERO_BYPASS_EN short-cuts zero operands
module mult_sched
   import mult_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              reset,
   mult_sched_if.slave       bus,
   output logic              dp_ld_input,
   output logic [1:0]        dp_state,
   output logic              dp_ready,
   output logic              dp_done,
   output logic [XLEN-1:0]   dp_a,
   output logic [XLEN-1:0]   dp_b,
   input  logic              dp_eqz,
   input  logic [2*XLEN-1:0] dp_product,
   output logic              busy
);

   localparam int IDW = $clog2(NREQ);

   sched_state_t      state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d, id_q, id_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic              busy_q, busy_d, resp_valid_q, resp_valid_d;
   logic              ld_q, ld_d, done_q, done_d;
   dp_state_t         dps_q, dps_d;

   logic [NREQ-1:0]   gnt;
   logic [IDW-1:0]    gidx;
   logic              gany;
   logic [XLEN-1:0]   a_arr [NREQ];
   logic [XLEN-1:0]   b_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = bus.req_a[g*XLEN +: XLEN];
      assign b_arr[g] = bus.req_b[g*XLEN +: XLEN];
   end

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gidx),
      .any (gany)
   );

   // Grant is combinational so a requester can be accepted in its first IDLE cycle.
   assign bus.req_ready = (state_q == S_IDLE && !reset) ? gnt : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      unique case (state_q)
         S_IDLE: begin
            if (gany) begin
               a_d   = a_arr[gidx];
               b_d   = b_arr[gidx];
               id_d  = gidx;
               ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
`ifdef MULT_SCHED_ZERO_BYPASS_EN
               if (a_arr[gidx] == '0 || b_arr[gidx] == '0) begin
                  state_d = S_RESP;
                  prod_d  = '0;
               end else begin
                  state_d = S_LOAD;
               end
`else
               state_d = S_LOAD;
`endif
            end
         end
         S_LOAD:    state_d = S_OPERATE;
         S_OPERATE: if (dp_eqz) state_d = S_DONE;
         S_DONE: begin
            prod_d  = dp_product;
            state_d = S_RESP;
         end
         S_RESP:    if (bus.resp_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      busy_d       = (state_d != S_IDLE);
      resp_valid_d = (state_d == S_RESP);
      ld_d         = (state_d == S_LOAD);
      done_d       = (state_d == S_DONE);
      dps_d        = (state_d == S_OPERATE) ? DP_OPERATE :
                     (state_d == S_DONE)    ? DP_DONE    : DP_READY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         prod_q       <= '0;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         ld_q         <= 1'b0;
         done_q       <= 1'b0;
         dps_q        <= DP_READY;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         prod_q       <= prod_d;
         busy_q       <= busy_d;
         resp_valid_q <= resp_valid_d;
         ld_q         <= ld_d;
         done_q       <= done_d;
         dps_q        <= dps_d;
      end
   end

   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_product = prod_q;
   assign bus.resp_id      = id_q;
   assign busy             = busy_q;
   assign dp_ld_input      = ld_q;
   assign dp_ready         = ld_q;
   assign dp_done          = done_q;
   assign dp_state         = dps_q;
   assign dp_a             = a_q;
   assign dp_b             = b_q;

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - randomized and directed checks of mult_sched against a transaction-level model
module tb_mult_sched;
   import mult_pkg::*;

   localparam int XLEN = 16;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              dp_ld_input, dp_ready, dp_done, dp_eqz, busy;
   logic [1:0]        dp_state;
   logic [XLEN-1:0]   dp_a, dp_b;
   logic [2*XLEN-1:0] dp_product;

   always #5 clk = ~clk;

   mult_sched_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

   mult_sched #(.XLEN(XLEN), .NREQ(NREQ)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dp_ld_input (dp_ld_input),
      .dp_state    (dp_state),
      .dp_ready    (dp_ready),
      .dp_done     (dp_done),
      .dp_a        (dp_a),
      .dp_b        (dp_b),
      .dp_eqz      (dp_eqz),
      .dp_product  (dp_product),
      .busy        (busy)
   );

   // External repeated-add datapath, held in reset with the scheduler.
   logic [XLEN-1:0]   dp_cnt;
   logic [2*XLEN-1:0] dp_acc;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_cnt <= '0;
         dp_acc <= '0;
      end else if (dp_ld_input) begin
         dp_cnt <= dp_b;
         dp_acc <= '0;
      end else if (dp_state == 2'd1 && dp_cnt != '0) begin
         dp_cnt <= dp_cnt - XLEN'(1);
         dp_acc <= dp_acc + (2*XLEN)'(dp_a);
      end
   end
   assign dp_eqz     = (dp_cnt == '0);
   assign dp_product = dp_acc;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int              id;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } job_t;
   job_t            pend[$];
   logic [NREQ-1:0] hs_mask = '0;
   logic            hold_low = 1'b0;
   logic            rand_rdy = 1'b0;

   task automatic push(input int id, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      job_t j;
      j.id = id;
      j.a  = a;
      j.b  = b;
      pend.push_back(j);
   endtask

   // Each requester holds its oldest pending job until it is accepted.
   always @(posedge clk) begin
      logic [NREQ*XLEN-1:0] va, vb;
      #2;
      va = '0;
      vb = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i] = 1'b0;
         for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == i) begin
               if (hs_mask[i]) begin
                  pend.delete(k);
               end
               break;
            end
         end
         for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == i) begin
               bus.req_valid[i] = 1'b1;
               va = va | ((NREQ*XLEN)'(pend[k].a) << (i*XLEN));
               vb = vb | ((NREQ*XLEN)'(pend[k].b) << (i*XLEN));
               break;
            end
         end
      end
      bus.req_a = va;
      bus.req_b = vb;
      hs_mask = '0;
      bus.resp_ready = hold_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // Transaction-level model: a request waits its latency in edges, then responds until taken.
   function automatic int lat_of(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef MULT_SCHED_ZERO_BYPASS_EN
      if (a == '0 || b == '0) return 0;
`endif
      return int'(b) + 3;
   endfunction

   function automatic int rr_win(input int ptr, input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (((v >> ((ptr + k) % NREQ)) & NREQ'(1)) != '0) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   logic              m_idle = 1'b1, m_resp = 1'b0, prev_rv = 1'b0;
   int                m_ptr = 0, m_cnt = 0, m_id = 0;
   logic [XLEN-1:0]   m_a = '0, m_b = '0;
   logic [2*XLEN-1:0] m_prod = '0;
   int                acc_log[$];
   int                last_acc_cyc = 0, first_rv_cyc = 0;

   always @(negedge clk) begin
      int w;
      logic [NREQ-1:0] exp_rdy, hs;
      if (reset) begin
         chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
         chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_product", 64'(bus.resp_product), 64'd0);
         chk("rst_id", 64'(bus.resp_id), 64'd0);
         chk("rst_dp_a", 64'(dp_a), 64'd0);
         chk("rst_dp_b", 64'(dp_b), 64'd0);
         m_idle  = 1'b1;
         m_resp  = 1'b0;
         m_ptr   = 0;
         prev_rv = 1'b0;
      end else begin
         w = rr_win(m_ptr, bus.req_valid);
         exp_rdy = (m_idle && w >= 0) ? (NREQ'(1) << w) : '0;
         chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
         chk("busy", 64'(busy), 64'(!m_idle));
         chk("resp_valid", 64'(bus.resp_valid), 64'(m_resp));
         if (m_resp) begin
            chk("resp_product", 64'(bus.resp_product), 64'(m_prod));
            chk("resp_id", 64'(bus.resp_id), 64'(m_id));
         end
         if (!m_idle) begin
            chk("dp_a", 64'(dp_a), 64'(m_a));
            chk("dp_b", 64'(dp_b), 64'(m_b));
         end
         if (bus.resp_valid && !prev_rv) first_rv_cyc = cyc;
         prev_rv = bus.resp_valid;
         hs = bus.req_valid & bus.req_ready;
         if (hs != '0) hs_mask = hs;
         if (m_idle) begin
            if (w >= 0) begin
               m_a    = XLEN'(bus.req_a >> (w*XLEN));
               m_b    = XLEN'(bus.req_b >> (w*XLEN));
               m_prod = (2*XLEN)'(m_a) * (2*XLEN)'(m_b);
               m_id   = w;
               m_ptr  = (w + 1) % NREQ;
               m_cnt  = lat_of(m_a, m_b);
               m_idle = 1'b0;
               m_resp = (m_cnt == 0);
               acc_log.push_back(w);
               last_acc_cyc = cyc + 1;
            end
         end else if (m_resp) begin
            if (bus.resp_ready) begin
               m_resp = 1'b0;
               m_idle = 1'b1;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) m_resp = 1'b1;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_resp(input int limit, input string nm);
      int n = 0;
      while (!bus.resp_valid && n < limit) begin
         tick();
         n++;
      end
      chk({nm, "_resp_seen"}, 64'(bus.resp_valid), 64'd1);
   endtask

   task automatic wait_idle(input int limit, input string nm);
      int n = 0;
      while ((busy || pend.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      chk({nm, "_idle"}, 64'(busy), 64'd0);
      chk({nm, "_drained"}, 64'(pend.size()), 64'd0);
   endtask

   initial begin
      int exp_ord[5];
      exp_ord = '{0, 1, 2, 3, 0};
      reset          = 1'b1;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // single request, 7*5
      push(0, 16'd7, 16'd5);
      wait_resp(100, "t1");
      chk("t1_latency", 64'(first_rv_cyc - last_acc_cyc), 64'd8);
      chk("t1_product", 64'(bus.resp_product), 64'd35);
      chk("t1_id", 64'(bus.resp_id), 64'd0);
      wait_idle(100, "t1");

      // bring the pointer back to requester 0, then all four contend twice each
      push(3, 16'd4, 16'd1);
      wait_idle(100, "t2a");
      acc_log.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NREQ; i++) push(i, XLEN'(10 + i), XLEN'(2 + i));
      wait_idle(300, "t2");
      chk("t2_count", 64'(acc_log.size() >= 5), 64'd1);
      for (int k = 0; k < 5 && k < acc_log.size(); k++)
         chk($sformatf("t2_order%0d", k), 64'(acc_log[k]), 64'(exp_ord[k]));

      // response back-pressure with another requester waiting
      hold_low = 1'b1;
      push(2, 16'd11, 16'd3);
      wait_resp(100, "t3");
      push(1, 16'd6, 16'd2);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t3_hold_valid", 64'(bus.resp_valid), 64'd1);
         chk("t3_hold_product", 64'(bus.resp_product), 64'd33);
         chk("t3_hold_id", 64'(bus.resp_id), 64'd2);
         chk("t3_hold_ready", 64'(bus.req_ready), 64'd0);
      end
      hold_low = 1'b0;
      wait_idle(100, "t3");

      // zero B operand
      push(1, 16'd9, 16'd0);
      wait_resp(100, "t4");
`ifdef MULT_SCHED_ZERO_BYPASS_EN
      chk("t4_latency", 64'(first_rv_cyc - last_acc_cyc), 64'd0);
`else
      chk("t4_latency", 64'(first_rv_cyc - last_acc_cyc), 64'd3);
`endif
      chk("t4_product", 64'(bus.resp_product), 64'd0);
      wait_idle(100, "t4");

      // reset in the middle of a long multiply
      push(3, 16'd3, 16'd100);
      repeat (20) tick();
      chk("t5_operating", 64'(dp_state), 64'd1);
      @(posedge clk);
      #3 reset = 1'b1;
      tick();
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_resp_valid", 64'(bus.resp_valid), 64'd0);
      @(posedge clk);
      #3 reset = 1'b0;
      push(2, 16'd2, 16'd2);
      wait_resp(100, "t5");
      chk("t5_product", 64'(bus.resp_product), 64'd4);
      chk("t5_id", 64'(bus.resp_id), 64'd2);
      wait_idle(100, "t5");

      // largest operands
      push(1, 16'hFFFF, 16'hFFFF);
      wait_resp(70000, "t6");
      chk("t6_latency", 64'(first_rv_cyc - last_acc_cyc), 64'd65538);
      chk("t6_product", 64'(bus.resp_product), 64'hFFFE0001);
      wait_idle(100, "t6");

      // random traffic with random response back-pressure
      rand_rdy = 1'b1;
      for (int t = 0; t < 40; t++) begin
         push(int'($urandom_range(0, NREQ - 1)),
              ($urandom_range(0, 5) == 0) ? XLEN'(0) : XLEN'($urandom),
              XLEN'($urandom_range(0, 12)));
         repeat ($urandom_range(0, 6)) tick();
      end
      wait_idle(4000, "t7");
      rand_rdy = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
